// File: rtl/serial_add_ctrl_if.sv
// Handshake and result bundle between user/switch logic and the bit-serial add sequencer.
//   start       request to begin an add
//   a, b, cin   operands and carry-in, captured when the request is accepted
//   busy        high while the serial add is in progress
//   done        one-cycle pulse, result valid
//   sum, cout   registered result, held until the next accepted request completes
interface serial_add_ctrl_if #(
    parameter int unsigned WIDTH = 4
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    // Requester side
    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    // Sequencer side
    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial add sequencer. Drives one external combinational full adder LSB-first
// over WIDTH cycles to form a + b + cin, then holds the result on sum/cout and
// pulses done for one cycle.
//   clk, reset_n          clock, asynchronous active-low reset
//   bus (slave)           start/a/b/cin in, busy/done/sum/cout out
//   fa_a, fa_b, fa_cin    operand bits and carry presented to the full adder
//   fa_sum, fa_cout       full adder results
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    serial_add_ctrl_if.slave   bus,
    output logic               fa_a,
    output logic               fa_b,
    output logic               fa_cin,
    input  logic               fa_sum,
    input  logic               fa_cout
);

    localparam int unsigned     IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              accept;
    logic              last;
    logic              run;

    logic [WIDTH-1:0]  a_sh_q;
    logic [WIDTH-1:0]  b_sh_q;
    logic [WIDTH-1:0]  sum_sh_q;
    logic              carry_q;
    logic [IDX_W-1:0]  idx_q;
    logic [WIDTH-1:0]  sum_q;
    logic              cout_q;
    logic              busy_q;
    logic              done_q;
    logic [WIDTH-1:0]  sum_shift;

    // New sum bit enters at the MSB so the LSB-first stream lands in place after WIDTH shifts
    assign sum_shift = {fa_sum, sum_sh_q[WIDTH-1:1]};
    assign run       = (state_q == RUN);

    // Next-state decode; accept marks an edge that captures fresh operands
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                last = (idx_q == LAST_IDX);
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand shifters, serial sum, carry and result registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            busy_q <= (state_d == RUN);
            done_q <= (state_d == DONE);
            if (accept) begin
                a_sh_q   <= bus.a;
                b_sh_q   <= bus.b;
                carry_q  <= bus.cin;
                idx_q    <= '0;
                sum_sh_q <= '0;
            end else if (run) begin
                sum_sh_q <= sum_shift;
                carry_q  <= fa_cout;
                a_sh_q   <= {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_q   <= {1'b0, b_sh_q[WIDTH-1:1]};
                idx_q    <= idx_q + IDX_W'(1);
                // Result registers change only on entry to DONE
                if (last) begin
                    sum_q  <= sum_shift;
                    cout_q <= fa_cout;
                end
            end
        end
    end

    // Full adder is only driven while a serial add is in progress
    assign fa_a   = run & a_sh_q[0];
    assign fa_b   = run & b_sh_q[0];
    assign fa_cin = run & carry_q;

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule
